pipeline_dump_tx: RTL
=====================

Name: pipeline_dump_tx

Overview:
- Debug-side transmitter for the pipelined CPU. It is the outbound end of the stepping/enable interface that a bench or host drives.
- On request, it stalls the pipeline via its enable, reads NUM_WORDS 32-bit debug words (PC, register file, …) through the CPU debug read port, and serialises them over a UART 8N1 line.
- Sits between the pipeline top and the board UART pin.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- NUM_WORDS, 33, debug words per dump (word 0 = PC, 1..32 = GPRs); range 1..(2**ADDR_W).
- ADDR_W, 6, debug address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- run_en  in  1  host-level pipeline run request.
- dump_req  in  1  one-cycle pulse; start a dump.
- dbg_data  in  32  debug read data; valid the cycle after dbg_addr changes.
- dbg_addr  out  ADDR_W  debug read address.
- pipe_enable  out  1  enable to pipeline; = run_en & ~busy.
- tx  out  1  UART serial line, idle high.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse after last stop bit.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - tx=1, busy=0, done=0, dbg_addr=0, pipe_enable=0.
  - Internal counters cleared; FSM in IDLE.
- Reset mid-frame aborts immediately: tx returns to 1 asynchronously; no partial completion, no done pulse.
- pipe_enable is registered and combinational in nothing: it is the registered value of run_en & ~busy_next. The pipeline freezes the same edge busy rises.
- FSM states and transitions:
  - IDLE: tx=1. dump_req=1 -> FETCH, with word_idx=0, busy=1. A dump_req while busy is ignored (not queued).
  - FETCH: dbg_addr=word_idx; wait exactly 1 cycle -> LOAD.
  - LOAD: shift_word <= dbg_data; byte_idx=0 -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA, with bit_idx=0.
  - DATA: tx = shift_word[byte_idx*8 + bit_idx], LSB first, CLKS_PER_BIT cycles per bit. After bit 7 -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then:
    - byte_idx<3: byte_idx++ -> START.
    - byte_idx==3 and word_idx<NUM_WORDS-1: word_idx++ -> FETCH.
    - Otherwise -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Byte order on the line: little-endian, byte 0 = dbg_data[7:0].
- Latency:
  - dump_req edge to tx falling: 3 cycles (FETCH, LOAD, first START cycle).
  - Each word occupies 2 + 40*CLKS_PER_BIT cycles.
  - Total busy time: NUM_WORDS*(2 + 40*CLKS_PER_BIT) + 1 cycles.
- Counters:
  - Baud counter width = clog2(CLKS_PER_BIT); wraps at CLKS_PER_BIT-1 with no drift.
  - word_idx width = ADDR_W; never exceeds NUM_WORDS-1.
- Simultaneous events:
  - dump_req in the same cycle as done: ignored (FSM still in DONE).
  - run_en toggling during a dump does not affect tx; pipe_enable follows run_en once busy=0.
- dbg_data is sampled only in LOAD; changes at any other time are irrelevant.

Decomposition:
- Package pipeline_dbg_pkg:
  - FSM state encoding (IDLE, FETCH, LOAD, START, DATA, STOP, DONE).
  - UART constants: START_BIT=0, STOP_BIT=1, BITS_PER_BYTE=8, BYTES_PER_WORD=4.
  - Debug address map constants: DBG_PC=0, DBG_GPR_BASE=1.
- One natural sub-module, uart_baud_tick: a CLKS_PER_BIT counter with a synchronous clear that emits a one-cycle tick at the end of each bit period. The top FSM advances only on tick.

Test Plan:
- Reset check: hold rst=0 while toggling clk and dump_req. Required: tx=1, busy=0, done=0, pipe_enable=0 throughout.
- Single word, little-endian order: CLKS_PER_BIT=4, NUM_WORDS=1, dbg_data=32'hA5C3_0F81, run_en=1, pulse dump_req.
  - pipe_enable falls at the same edge busy rises.
  - Line carries bytes 0x81, 0x0F, 0xC3, 0xA5, each as start 0 + 8 LSB-first bits + stop 1.
  - done pulses at cycle 2+160+1; pipe_enable returns to 1 next cycle.
- Multi-word address sequencing: NUM_WORDS=3, model returns dbg_data = 32'h1000_0000 + addr.
  - dbg_addr steps 0, 1, 2.
  - 12 bytes received: 00 00 00 10, 01 00 00 10, 02 00 00 10.
  - busy width = 3*162+1 cycles.
- Request while busy: a second dump_req mid-byte of word 1. Required: no restart, exactly NUM_WORDS*4 bytes, one done pulse.
- Reset mid-frame: drive rst=0 during a DATA bit of byte 2. Required: tx=1 immediately.
  - After release, a new dump_req produces a complete, correct frame starting from word 0.
- Baud accuracy: CLKS_PER_BIT=868. Measure the first start bit and every data bit width. Required: each = 868 cycles exactly.

Source files
------------

// File: rtl/pipeline_dbg_pkg.sv
// Shared definitions for the pipeline debug-dump transmitter: FSM encoding,
// UART framing constants, debug address map and a bit-select helper.
package pipeline_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5,
    ST_DONE  = 3'd6
  } dump_state_e;

  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;
  localparam int   BITS_PER_BYTE  = 8;
  localparam int   BYTES_PER_WORD = 4;

  localparam int   DBG_PC         = 0;
  localparam int   DBG_GPR_BASE   = 1;

  // Line bit for a given byte/bit position of a little-endian word.
  function automatic logic word_bit(input logic [31:0] word,
                                    input logic [1:0]  byte_idx,
                                    input logic [2:0]  bit_idx);
    return word[{byte_idx, bit_idx}];
  endfunction

endpackage

// File: rtl/pipeline_dump_tx_uart_baud_tick.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and flags the last cycle of
// each period; a synchronous clear re-aligns it to the start of a frame.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Period counter, wraps on the last cycle so consecutive bits never drift.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST_CNT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == LAST_CNT) && !i_clear;

endmodule

// File: rtl/pipeline_dump_tx.sv
// Debug dump transmitter: freezes the pipeline, reads NUM_WORDS debug words
// through the debug port and sends them little-endian over a UART 8N1 line.
module pipeline_dump_tx
  import pipeline_dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_WORDS    = 33,
  parameter int ADDR_W       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_en,
  input  logic              dump_req,
  input  logic [31:0]       dbg_data,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic              pipe_enable,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  // Word 0 is the PC, so the last word index is also the last GPR address.
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DBG_GPR_BASE + NUM_WORDS - 2);
  localparam logic [2:0]        LAST_BIT  = 3'(BITS_PER_BYTE - 1);
  localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  dump_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_word_idx, w_word_nxt;
  logic [1:0]        r_byte_idx, w_byte_nxt;
  logic [2:0]        r_bit_idx, w_bit_nxt;
  logic [31:0]       r_shift, w_shift_nxt;
  logic              w_tick, w_baud_clr;

  logic              r_tx, r_busy, r_done, r_pipe_en;
  logic [ADDR_W-1:0] r_dbg_addr;
  logic              w_tx_nxt, w_busy_nxt, w_done_nxt, w_pipe_en_nxt;

  assign w_baud_clr = !((r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP));

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_clear(w_baud_clr),
    .o_tick (w_tick)
  );

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_word_idx <= '0;
      r_byte_idx <= 2'd0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_idx <= w_word_nxt;
      r_byte_idx <= w_byte_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  // Next-state logic; bit-timed states only move on a baud tick.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word_idx;
    w_byte_nxt  = r_byte_idx;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    case (r_state)
      ST_IDLE: begin
        if (dump_req) begin
          w_state_nxt = ST_FETCH;
          w_word_nxt  = ADDR_W'(DBG_PC);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_shift_nxt = dbg_data;
        w_byte_nxt  = 2'd0;
        w_state_nxt = ST_START;
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = 3'd0;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (!w_tick) begin
          w_state_nxt = ST_DATA;
        end else if (r_bit_idx == LAST_BIT) begin
          w_state_nxt = ST_STOP;
        end else begin
          w_bit_nxt = r_bit_idx + 3'd1;
        end
      end
      ST_STOP: begin
        if (!w_tick) begin
          w_state_nxt = ST_STOP;
        end else if (r_byte_idx != LAST_BYTE) begin
          w_byte_nxt  = r_byte_idx + 2'd1;
          w_state_nxt = ST_START;
        end else if (r_word_idx < LAST_WORD) begin
          w_word_nxt  = r_word_idx + ADDR_W'(1);
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they line up with it after the edge.
  always_comb begin
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
    w_done_nxt    = (w_state_nxt == ST_DONE);
    w_pipe_en_nxt = run_en & ~w_busy_nxt;
    case (w_state_nxt)
      ST_START: w_tx_nxt = START_BIT;
      ST_DATA:  w_tx_nxt = word_bit(w_shift_nxt, w_byte_nxt, w_bit_nxt);
      default:  w_tx_nxt = STOP_BIT;
    endcase
  end

  // Output registers; reset drives the line idle-high at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx       <= STOP_BIT;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pipe_en  <= 1'b0;
      r_dbg_addr <= '0;
    end else begin
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pipe_en  <= w_pipe_en_nxt;
      r_dbg_addr <= w_word_nxt;
    end
  end

  assign tx          = r_tx;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pipe_enable = r_pipe_en;
  assign dbg_addr    = r_dbg_addr;

endmodule
